// File: rtl/ack_tx_arbiter.sv
// ACK request sequencer and egress arbiter: triggers the ACK generator, captures its fixed-timing
// burst into a local buffer and merges the buffered ACK into the order stream at packet boundaries.
module ack_tx_arbiter #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int ACK_WORDS            = 3,
    parameter int GEN_LATENCY          = 2,
    parameter int PEND_W               = 4,
    parameter int STARVE_MAX           = 4
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              ack_req,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   ack_tuser,
    output logic                              gen_send_ack,
    input  logic                              gen_rdy,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    gen_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  gen_tkeep,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    output logic [PEND_W-1:0]                 pend_cnt,
    output logic [15:0]                       drop_cnt,
    output logic                              gen_err
);

    localparam int DW         = C_S_AXIS_DATA_WIDTH;
    localparam int KW         = C_S_AXIS_DATA_WIDTH / 8;
    localparam int TU         = C_S_AXIS_TUSER_WIDTH;
    localparam int IDX_W      = (ACK_WORDS > 1) ? $clog2(ACK_WORDS) : 1;
    localparam int WAIT_INIT  = (GEN_LATENCY > 1) ? GEN_LATENCY - 2 : 0;
    localparam int WAIT_W     = $clog2(WAIT_INIT + 2);
    localparam int STARVE_W   = $clog2(STARVE_MAX + 1);
    localparam logic [PEND_W-1:0]   PEND_MAX   = {PEND_W{1'b1}};
    localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(ACK_WORDS - 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    typedef enum logic [1:0] {C_IDLE, C_TRIG, C_WAIT, C_CAP} cap_state_t;
    typedef enum logic [1:0] {O_IDLE, O_ORD, O_ACK} out_state_t;

    cap_state_t           cap_q, cap_d;
    out_state_t           ost_q, ost_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [IDX_W-1:0]     cidx_q, cidx_d;
    logic [IDX_W-1:0]     oidx_q, oidx_d;
    logic [STARVE_W-1:0]  starve_q, starve_d;
    logic [PEND_W-1:0]    pend_q, pend_d;
    logic [15:0]          drop_q, drop_d;
    logic                 send_q, send_d;
    logic                 buf_full_q, buf_full_d;
    logic                 err_q, err_d;
    logic                 cap_en_s, buf_set_s, buf_clr_s, dec_s;
    logic [DW-1:0]        buf_data_q [ACK_WORDS];
    logic [KW-1:0]        buf_keep_q [ACK_WORDS];

    assign gen_send_ack = send_q;
    assign pend_cnt     = pend_q;
    assign drop_cnt     = drop_q;
    assign gen_err      = err_q;

    // Capture FSM: one trigger per empty buffer, then ACK_WORDS back-to-back captures.
    always_comb begin
        cap_d     = cap_q;
        wait_d    = wait_q;
        cidx_d    = cidx_q;
        cap_en_s  = 1'b0;
        buf_set_s = 1'b0;
        dec_s     = 1'b0;
        case (cap_q)
            C_IDLE: begin
                if (pend_q != PEND_W'(0) && !buf_full_q) begin
                    cap_d = C_TRIG;
                end else begin
                    cap_d = C_IDLE;
                end
            end
            C_TRIG: begin
                dec_s  = 1'b1;
                wait_d = WAIT_W'(WAIT_INIT);
                if (GEN_LATENCY > 1) begin
                    cap_d = C_WAIT;
                end else begin
                    cap_d = C_CAP;
                end
            end
            C_WAIT: begin
                if (wait_q == WAIT_W'(0)) begin
                    cap_d = C_CAP;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            C_CAP: begin
                cap_en_s = 1'b1;
                if (cidx_q == IDX_LAST) begin
                    cidx_d    = IDX_W'(0);
                    buf_set_s = 1'b1;
                    cap_d     = C_IDLE;
                end else begin
                    cidx_d = cidx_q + IDX_W'(1);
                end
            end
            default: begin
                cap_d = C_IDLE;
            end
        endcase
    end

    // Pending-request counter with saturation and drop accounting; error flag and buffer-full flag.
    always_comb begin
        pend_d     = pend_q;
        drop_d     = drop_q;
        send_d     = (cap_d == C_TRIG);
        err_d      = err_q | (cap_en_s & ~gen_rdy);
        buf_full_d = buf_full_q;
        case ({ack_req, dec_s})
            2'b10: begin
                if (pend_q == PEND_MAX) begin
                    drop_d = drop_q + 16'd1;
                end else begin
                    pend_d = pend_q + PEND_W'(1);
                end
            end
            2'b01:   pend_d = pend_q - PEND_W'(1);
            default: pend_d = pend_q;
        endcase
        if (buf_set_s) begin
            buf_full_d = 1'b1;
        end else if (buf_clr_s) begin
            buf_full_d = 1'b0;
        end else begin
            buf_full_d = buf_full_q;
        end
    end

    // Output FSM: whole packets only; order traffic wins until STARVE_MAX packets pass a buffered ACK.
    always_comb begin
        ost_d         = ost_q;
        oidx_d        = oidx_q;
        starve_d      = starve_q;
        buf_clr_s     = 1'b0;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = {DW{1'b0}};
        m_axis_tkeep  = {KW{1'b0}};
        m_axis_tuser  = {TU{1'b0}};
        m_axis_tlast  = 1'b0;
        case (ost_q)
            O_IDLE: begin
                if (s_axis_tvalid && !(buf_full_q && starve_q >= STARVE_LIM)) begin
                    ost_d = O_ORD;
                end else if (buf_full_q) begin
                    ost_d = O_ACK;
                end else begin
                    ost_d = O_IDLE;
                end
            end
            O_ORD: begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tkeep  = s_axis_tkeep;
                m_axis_tuser  = s_axis_tuser;
                m_axis_tlast  = s_axis_tlast;
                if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                    ost_d = O_IDLE;
                    if (!buf_full_q) begin
                        starve_d = STARVE_W'(0);
                    end else if (starve_q != STARVE_LIM) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end else begin
                        starve_d = starve_q;
                    end
                end else begin
                    ost_d = O_ORD;
                end
            end
            O_ACK: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = buf_data_q[oidx_q];
                m_axis_tkeep  = buf_keep_q[oidx_q];
                m_axis_tuser  = ack_tuser;
                m_axis_tlast  = (oidx_q == IDX_LAST);
                if (m_axis_tready && oidx_q == IDX_LAST) begin
                    oidx_d    = IDX_W'(0);
                    buf_clr_s = 1'b1;
                    starve_d  = STARVE_W'(0);
                    ost_d     = O_IDLE;
                end else if (m_axis_tready) begin
                    oidx_d = oidx_q + IDX_W'(1);
                end else begin
                    oidx_d = oidx_q;
                end
            end
            default: begin
                ost_d = O_IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cap_q      <= C_IDLE;
            ost_q      <= O_IDLE;
            wait_q     <= WAIT_W'(0);
            cidx_q     <= IDX_W'(0);
            oidx_q     <= IDX_W'(0);
            starve_q   <= STARVE_W'(0);
            pend_q     <= PEND_W'(0);
            drop_q     <= 16'd0;
            send_q     <= 1'b0;
            buf_full_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cap_q      <= cap_d;
            ost_q      <= ost_d;
            wait_q     <= wait_d;
            cidx_q     <= cidx_d;
            oidx_q     <= oidx_d;
            starve_q   <= starve_d;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
            send_q     <= send_d;
            buf_full_q <= buf_full_d;
            err_q      <= err_d;
        end
    end

    // ACK word buffer; generator cannot stall, so every capture cycle writes unconditionally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < ACK_WORDS; i++) begin
                buf_data_q[i] <= {DW{1'b0}};
                buf_keep_q[i] <= {KW{1'b0}};
            end
        end else if (cap_en_s) begin
            buf_data_q[cidx_q] <= gen_tdata;
            buf_keep_q[cidx_q] <= gen_tkeep;
        end
    end

endmodule

// File: tb/tb_ack_tx_arbiter.sv
// Directed bench for ack_tx_arbiter: behavioural ACK generator, order-packet source and an
// ACK scoreboard, with immediate-assertion checks at every comparison point.
module tb_ack_tx_arbiter;

    localparam int DW = 256;
    localparam int KW = 32;
    localparam int TU = 128;
    localparam logic [TU-1:0] ACK_TUSER = {4{32'hACCE55ED}};

    logic            clk = 1'b0;
    logic            resetn;
    logic            ack_req;
    logic [TU-1:0]   ack_tuser;
    logic            gen_send_ack;
    logic            gen_rdy;
    logic [DW-1:0]   gen_tdata;
    logic [KW-1:0]   gen_tkeep;
    logic [DW-1:0]   s_axis_tdata;
    logic [KW-1:0]   s_axis_tkeep;
    logic [TU-1:0]   s_axis_tuser;
    logic            s_axis_tvalid;
    logic            s_axis_tlast;
    logic            s_axis_tready;
    logic [DW-1:0]   m_axis_tdata;
    logic [KW-1:0]   m_axis_tkeep;
    logic [TU-1:0]   m_axis_tuser;
    logic            m_axis_tvalid;
    logic            m_axis_tlast;
    logic            m_axis_tready;
    logic [3:0]      pend_cnt;
    logic [15:0]     drop_cnt;
    logic            gen_err;

    ack_tx_arbiter dut (
        .clk(clk), .resetn(resetn), .ack_req(ack_req), .ack_tuser(ack_tuser),
        .gen_send_ack(gen_send_ack), .gen_rdy(gen_rdy), .gen_tdata(gen_tdata), .gen_tkeep(gen_tkeep),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .pend_cnt(pend_cnt), .drop_cnt(drop_cnt), .gen_err(gen_err)
    );

    always #5 clk = ~clk;

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] ackq[$];
    int            gen_t = -1;
    logic [15:0]   ack_seq = 16'd0;
    logic [15:0]   gen_seq = 16'd0;
    logic          gen_rdy_sticky = 1'b0;
    logic          gen_force_low = 1'b0;
    logic          prev_trig = 1'b0;
    int            triggers = 0;
    int            ack_beats = 0;
    int            ack_idx = 0;
    logic          ord_en = 1'b0;
    logic          ord_stop = 1'b0;
    logic          ord_in_pkt = 1'b0;
    logic [31:0]   ord_beat = 32'd0;
    int            ord_pkts = 0;
    logic          buf_watch = 1'b0;
    int            ord_after = 0;
    logic          stall_pend = 1'b0;
    logic [DW-1:0] stall_data = '0;
    int            ack_stalls = 0;
    logic          tready_toggle = 1'b0;
    logic          tready_base = 1'b1;

    function automatic logic [DW-1:0] ack_word(input logic [15:0] seq, input int i);
        logic [7:0] ib;
        ib = 8'(i);
        return {8{seq, ib, 8'hA5}};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample/score at negedge, then drive next-cycle inputs just after posedge.
    task automatic step();
        logic          s_hs;
        logic          s_last;
        logic [DW-1:0] exp_w;
        logic [KW-1:0] exp_k;
        @(negedge clk);
        if (gen_send_ack) begin
            chk("trig_single_cycle", {255'd0, prev_trig}, '0);
            triggers++;
            gen_seq = ack_seq;
            for (int i = 0; i < 3; i++) ackq.push_back(ack_word(ack_seq, i));
            ack_seq = ack_seq + 16'd1;
            gen_t = 0;
        end
        prev_trig = gen_send_ack;
        s_hs   = s_axis_tvalid && s_axis_tready;
        s_last = s_axis_tlast;
        if (stall_pend) begin
            chk("stall_valid", {255'd0, m_axis_tvalid}, 256'd1);
            chk("stall_data", m_axis_tdata, stall_data);
        end
        stall_pend = m_axis_tvalid && !m_axis_tready;
        stall_data = m_axis_tdata;
        if (stall_pend && m_axis_tuser == ACK_TUSER) ack_stalls++;
        if (m_axis_tvalid && m_axis_tready) begin
            if (m_axis_tuser == ACK_TUSER) begin
                chk("ack_mid_order_pkt", {255'd0, ord_in_pkt}, '0);
                if (ack_idx == 0 && buf_watch) begin
                    chk("starve_pkts_before_ack", DW'(ord_after), DW'(4));
                    buf_watch = 1'b0;
                end
                if (ackq.size() == 0) begin
                    chk("ack_unexpected", 256'd1, 256'd0);
                end else begin
                    exp_w = ackq.pop_front();
                    chk("ack_data", m_axis_tdata, exp_w);
                end
                exp_k = (ack_idx == 2) ? 32'hc0000000 : 32'hffffffff;
                chk("ack_keep", DW'(m_axis_tkeep), DW'(exp_k));
                chk("ack_last", {255'd0, m_axis_tlast}, {255'd0, (ack_idx == 2)});
                ack_beats++;
                ack_idx = (ack_idx == 2) ? 0 : ack_idx + 1;
            end else begin
                chk("ord_handshake", {255'd0, s_hs}, 256'd1);
                chk("ord_data", m_axis_tdata, s_axis_tdata);
                chk("ord_user", DW'(m_axis_tuser), DW'(s_axis_tuser));
                chk("ord_last", {255'd0, m_axis_tlast}, {255'd0, s_axis_tlast});
                ord_in_pkt = !m_axis_tlast;
                if (m_axis_tlast) begin
                    ord_pkts++;
                    if (buf_watch) ord_after++;
                end
            end
        end
        if (gen_t == 4 && ord_en) begin
            buf_watch = 1'b1;
            ord_after = 0;
        end
        @(posedge clk);
        #1;
        ack_req = 1'b0;
        if (gen_t >= 0) gen_t++;
        if (gen_t >= 2 && gen_t <= 4) begin
            gen_tdata      = ack_word(gen_seq, gen_t - 2);
            gen_tkeep      = (gen_t == 4) ? 32'hc0000000 : 32'hffffffff;
            gen_rdy_sticky = 1'b1;
        end else begin
            gen_tdata = '0;
            gen_tkeep = '0;
            if (gen_t > 4) gen_t = -1;
        end
        gen_rdy = gen_rdy_sticky & ~gen_force_low;
        if (s_hs) begin
            ord_beat = ord_beat + 32'd1;
            if (s_last && ord_stop) begin
                ord_en   = 1'b0;
                ord_stop = 1'b0;
            end
        end
        s_axis_tvalid = ord_en;
        s_axis_tdata  = {8{ord_beat}};
        s_axis_tkeep  = 32'hffffffff;
        s_axis_tuser  = {96'd0, ord_beat};
        s_axis_tlast  = (ord_beat[1:0] == 2'd3);
        m_axis_tready = tready_toggle ? ~m_axis_tready : tready_base;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_send"},   {255'd0, gen_send_ack}, '0);
        chk({tag, "_mvalid"}, {255'd0, m_axis_tvalid}, '0);
        chk({tag, "_sready"}, {255'd0, s_axis_tready}, '0);
        chk({tag, "_mdata"},  m_axis_tdata, '0);
        chk({tag, "_mkeep"},  DW'(m_axis_tkeep), '0);
        chk({tag, "_muser"},  DW'(m_axis_tuser), '0);
        chk({tag, "_mlast"},  {255'd0, m_axis_tlast}, '0);
        chk({tag, "_pend"},   DW'(pend_cnt), '0);
        chk({tag, "_drop"},   DW'(drop_cnt), '0);
        chk({tag, "_err"},    {255'd0, gen_err}, '0);
    endtask

    int base_beats;
    int base_trig;
    int base_pkts;

    initial begin
        resetn        = 1'b0;
        ack_req       = 1'b0;
        ack_tuser     = ACK_TUSER;
        gen_rdy       = 1'b0;
        gen_tdata     = '0;
        gen_tkeep     = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        run(3);
        chk_zero_outputs("reset");
        resetn = 1'b1;
        run(2);

        // 1: single request, trigger one cycle after pend_cnt rises, three ACK beats.
        ack_req = 1'b1;
        step();
        chk("t1_pend_up", DW'(pend_cnt), DW'(1));
        chk("t1_no_trig_yet", {255'd0, gen_send_ack}, '0);
        step();
        chk("t1_trig", {255'd0, gen_send_ack}, 256'd1);
        step();
        chk("t1_pend_down", DW'(pend_cnt), '0);
        chk("t1_trig_done", {255'd0, gen_send_ack}, '0);
        run(15);
        chk("t1_beats", DW'(ack_beats), DW'(3));
        chk("t1_queue_empty", DW'(ackq.size()), '0);

        // 2: 17 back-to-back requests with egress stalled: saturate at 15, one drop, then 16 ACKs.
        base_beats  = ack_beats;
        base_trig   = triggers;
        tready_base = 1'b0;
        for (int k = 0; k < 17; k++) begin
            ack_req = 1'b1;
            step();
        end
        chk("t2_pend_sat", DW'(pend_cnt), DW'(15));
        chk("t2_drop", DW'(drop_cnt), DW'(1));
        tready_base = 1'b1;
        run(260);
        chk("t2_triggers", DW'(triggers - base_trig), DW'(16));
        chk("t2_beats", DW'(ack_beats - base_beats), DW'(48));
        chk("t2_pend_end", DW'(pend_cnt), '0);
        chk("t2_drop_hold", DW'(drop_cnt), DW'(1));

        // 3: continuous 4-beat order packets; the ACK waits exactly four packets, never mid-packet.
        base_beats = ack_beats;
        base_pkts  = ord_pkts;
        ord_en     = 1'b1;
        run(3);
        ack_req = 1'b1;
        step();
        run(60);
        ord_stop = 1'b1;
        for (int k = 0; k < 20 && ord_en; k++) step();
        chk("t3_order_stopped", {255'd0, ord_en}, '0);
        run(10);
        chk("t3_beats", DW'(ack_beats - base_beats), DW'(3));
        chk("t3_starve_seen", {255'd0, buf_watch}, '0);
        chk("t3_order_flowed", {255'd0, (ord_pkts - base_pkts > 4)}, 256'd1);

        // 4: toggling backpressure during ACK output.
        base_beats    = ack_beats;
        tready_toggle = 1'b1;
        ack_req       = 1'b1;
        step();
        run(30);
        tready_toggle = 1'b0;
        tready_base   = 1'b1;
        run(3);
        chk("t4_beats", DW'(ack_beats - base_beats), DW'(3));
        chk("t4_stalled", {255'd0, (ack_stalls > 0)}, 256'd1);

        // 5: generator flag low during capture raises sticky gen_err; ACK still delivered.
        base_beats    = ack_beats;
        chk("t5_err_before", {255'd0, gen_err}, '0);
        gen_force_low = 1'b1;
        ack_req       = 1'b1;
        step();
        run(15);
        gen_force_low = 1'b0;
        run(5);
        chk("t5_err_sticky", {255'd0, gen_err}, 256'd1);
        chk("t5_beats", DW'(ack_beats - base_beats), DW'(3));

        // 6: reset asserted mid-capture; outputs clear at once, next request yields a clean ACK.
        ack_req = 1'b1;
        step();
        for (int k = 0; k < 20 && gen_t != 3; k++) step();
        chk("t6_mid_capture", DW'(gen_t), DW'(3));
        #1;
        resetn = 1'b0;
        #1;
        chk_zero_outputs("t6_async");
        run(2);
        ackq.delete();
        ack_idx    = 0;
        gen_t      = -1;
        prev_trig  = 1'b0;
        stall_pend = 1'b0;
        resetn     = 1'b1;
        run(2);
        base_beats = ack_beats;
        ack_req    = 1'b1;
        step();
        run(20);
        chk("t6_beats", DW'(ack_beats - base_beats), DW'(3));
        chk("t6_queue_empty", DW'(ackq.size()), '0);
        chk("t6_err_cleared", {255'd0, gen_err}, '0);
        chk("t6_pend_end", DW'(pend_cnt), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
